key_responder: RTL

Responder end of the req/req_key/ack key-sequence handshake. An always-requesting initiator advances its 4-bit key once per ack. This block accepts each request and checks the key against the expected incrementing sequence. It returns a single-cycle ack after a programmable service latency and reports sequence errors and completed-transaction count for the loop testbench/scoreboard.

---
 rtl/key_responder_pkg.sv | 18 +
 rtl/key_responder_if.sv | 28 ++
 rtl/key_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/key_responder_pkg.sv
// Shared types and widths for the key-sequence responder.
//   resp_state_t  : responder FSM states
//   KEY_W_DEFAULT : default key width
//   CNT_W         : completed-transaction counter width
//   WAIT_W        : service-latency counter width (latency up to 15)
package key_resp_pkg;

  localparam int unsigned KEY_W_DEFAULT = 4;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned WAIT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/key_responder_if.sv
// req/req_key/ack key-sequence handshake plus responder status.
//   req, req_key : request and its key (initiator -> responder)
//   ack          : one-cycle acknowledge (responder -> initiator)
//   err, err_key : sticky sequence error and first offending key
//   done_count   : saturating completed-transaction count
interface key_responder_if #(
  parameter int unsigned KEY_W = key_resp_pkg::KEY_W_DEFAULT
);
  import key_resp_pkg::*;

  logic                 req;
  logic [KEY_W-1:0]     req_key;
  logic                 ack;
  logic                 err;
  logic [KEY_W-1:0]     err_key;
  logic [CNT_W-1:0]     done_count;

  modport master (
    output req, req_key,
    input  ack, err, err_key, done_count
  );

  modport slave (
    input  req, req_key,
    output ack, err, err_key, done_count
  );

endinterface

// File: rtl/key_responder.sv
// Responder end of the key-sequence handshake: accepts one request at a time,
// checks its key against the expected incrementing sequence, and returns a
// one-cycle ack LATENCY cycles after capture.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : handshake/status interface (slave side); all outputs are flops
module key_responder
  import key_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned KEY_W   = KEY_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  key_responder_if.slave bus
);

  resp_state_t        state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [KEY_W-1:0]   expected_q, expected_d;
  logic               err_q, err_d;
  logic [KEY_W-1:0]   err_key_q, err_key_d;
  logic [CNT_W-1:0]   done_q, done_d;
  logic               ack_q, ack_d;

  // Next-state, latency counter, key check and counters
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expected_d = expected_q;
    err_d      = err_q;
    err_key_d  = err_key_q;
    done_d     = done_q;
    ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cnt_d   = WAIT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ACK : WAIT;
          // Mismatch flags the error but the expected key always resyncs
          // to the initiator so one slip reports only once.
          if (bus.req_key != expected_q) begin
            err_d = 1'b1;
            if (!err_q) begin
              err_key_d = bus.req_key;
            end
          end
          expected_d = bus.req_key + KEY_W'(1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (done_q != {CNT_W{1'b1}}) begin
          done_d = done_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // ack flop tracks entry into ACK so it is high exactly in that cycle
    ack_d = (state_d == ACK);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      expected_q <= '0;
      err_q      <= 1'b0;
      err_key_q  <= '0;
      done_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      err_key_q  <= err_key_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.err_key    = err_key_q;
  assign bus.done_count = done_q;

endmodule
